// File: rtl/board_render_seq_pkg.sv
// Shared board geometry, cell codes and palette for the board renderer.
// The FSM state type lives here too so a bench or debug probe can decode it.
package board_render_seq_pkg;

    localparam int BOARD_COLS   = 10;
    localparam int BOARD_ROWS   = 20;
    localparam int BOARD_CELL_W = 64;
    localparam int BOARD_CELL_H = 24;

    typedef enum logic [2:0] {
        CELL_EMPTY   = 3'd0,
        CELL_CYAN    = 3'd1,
        CELL_YELLOW  = 3'd2,
        CELL_MAGENTA = 3'd3,
        CELL_GREEN   = 3'd4,
        CELL_RED     = 3'd5,
        CELL_BLUE    = 3'd6,
        CELL_ORANGE  = 3'd7
    } cell_code_t;

    // Colours are RRR_GGG_BBB, indexed by cell code.
    localparam logic [8:0] PALETTE [8] = '{
        9'h000, 9'h03F, 9'h1F8, 9'h1C7, 9'h038, 9'h1C0, 9'h007, 9'h1E0
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_ISSUE,
        ST_WAIT,
        ST_ADV,
        ST_FDONE
    } render_state_t;

    function automatic logic [8:0] paletteLookup(input logic [2:0] code);
        return PALETTE[code];
    endfunction

endpackage

// File: rtl/board_render_seq_palette.sv
// Combinational cell-code to colour lookup.
module cell_palette
    import board_render_seq_pkg::*;
(
    input  logic [2:0] i_code,
    output logic [8:0] o_color
);

    assign o_color = paletteLookup(i_code);

endmodule

// File: rtl/board_render_seq.sv
// Walks the board row by row, reads each cell code from RAM and hands one
// box per cell to an external drawer, waiting for its completion pulse.
module board_render_seq
    import board_render_seq_pkg::*;
#(
    parameter int COLS   = BOARD_COLS,
    parameter int ROWS   = BOARD_ROWS,
    parameter int CELL_W = BOARD_CELL_W,
    parameter int CELL_H = BOARD_CELL_H
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       frame_req,
    output logic [7:0] cell_rd_addr,
    input  logic [2:0] cell_rd_data,
    output logic       box_start,
    output logic [9:0] box_x0,
    output logic [8:0] box_y0,
    output logic [8:0] box_color,
    input  logic       box_done,
    output logic       frame_busy,
    output logic       frame_done
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [9:0]       STEP_X   = 10'(CELL_W);
    localparam logic [8:0]       STEP_Y   = 9'(CELL_H);

    render_state_t    r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [7:0]       r_addr;
    logic [9:0]       r_x0;
    logic [8:0]       r_y0;
    logic [8:0]       r_color;
    logic             r_pending;
    logic             r_boxStart;
    logic             r_frameBusy;
    logic             r_frameDone;
    logic [8:0]       w_cellColor;

    cell_palette u_palette (
        .i_code  (cell_rd_data),
        .o_color (w_cellColor)
    );

    // Coordinates and address are stepped by accumulators so no multiplier
    // is needed; strobes are registered and set on entry to their state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_color     <= '0;
            r_pending   <= 1'b0;
            r_boxStart  <= 1'b0;
            r_frameBusy <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_boxStart  <= 1'b0;
            r_frameDone <= 1'b0;
            if (frame_req && r_frameBusy) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (frame_req || r_pending) begin
                        r_state     <= ST_READ;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_addr      <= '0;
                        r_x0        <= '0;
                        r_y0        <= '0;
                        r_pending   <= 1'b0;
                        r_frameBusy <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_color    <= w_cellColor;
                    r_boxStart <= 1'b1;
                    r_state    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (box_done) begin
                        r_state <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    if (r_col < LAST_COL) begin
                        r_col   <= r_col + 1'b1;
                        r_addr  <= r_addr + 8'd1;
                        r_x0    <= r_x0 + STEP_X;
                        r_state <= ST_READ;
                    end else if (r_row < LAST_ROW) begin
                        r_col   <= '0;
                        r_x0    <= '0;
                        r_row   <= r_row + 1'b1;
                        r_addr  <= r_addr + 8'd1;
                        r_y0    <= r_y0 + STEP_Y;
                        r_state <= ST_READ;
                    end else begin
                        r_frameDone <= 1'b1;
                        r_state     <= ST_FDONE;
                    end
                end
                ST_FDONE: begin
                    r_frameBusy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_frameBusy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cell_rd_addr = r_addr;
    assign box_start    = r_boxStart;
    assign box_x0       = r_x0;
    assign box_y0       = r_y0;
    assign box_color    = r_color;
    assign frame_busy   = r_frameBusy;
    assign frame_done   = r_frameDone;

endmodule

// File: tb/tb_board_render_seq.sv
// Scoreboard bench for board_render_seq: expected boxes are queued per frame
// and a monitor pops one per box_start, with a RAM and drawer model attached.
module tb_board_render_seq;

    typedef struct packed {
        logic [7:0] addr;
        logic [9:0] x0;
        logic [8:0] y0;
        logic [8:0] color;
    } cell_exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_req = 1'b0;
    logic [7:0] cell_rd_addr;
    logic [2:0] cell_rd_data = 3'd0;
    logic       box_start;
    logic [9:0] box_x0;
    logic [8:0] box_y0;
    logic [8:0] box_color;
    logic       box_done = 1'b0;
    logic       frame_busy;
    logic       frame_done;

    logic [2:0] mem [200];
    logic [8:0] expPalette [8] = '{9'h000, 9'h03F, 9'h1F8, 9'h1C7, 9'h038, 9'h1C0, 9'h007, 9'h1E0};
    cell_exp_t  expQ [$];

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int phaseStarts = 0;
    int phaseDone = 0;
    int firstStartCyc = 0;
    int lastStartCyc = 0;
    int doneCyc = 0;
    int doneDelay = 5;
    bit spurMode = 1'b0;
    logic [9:0] cell14X = '0;
    logic [8:0] cell14Y = '0;
    logic [8:0] cell14Color = '0;

    board_render_seq dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .frame_req    (frame_req),
        .cell_rd_addr (cell_rd_addr),
        .cell_rd_data (cell_rd_data),
        .box_start    (box_start),
        .box_x0       (box_x0),
        .box_y0       (box_y0),
        .box_color    (box_color),
        .box_done     (box_done),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cycleCount <= cycleCount + 1;

    // Board RAM with one cycle of read latency.
    always @(posedge CLOCK_50) begin
        if (cell_rd_addr < 8'd200) cell_rd_data <= mem[cell_rd_addr];
        else cell_rd_data <= 3'd0;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Drawer model: done pulses doneDelay+1 cycles after start; spurMode adds
    // stray done pulses in ISSUE, READ and LATCH of the following cell.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            box_done = 1'b0;
            if (box_start) begin
                if (spurMode) box_done = 1'b1;
                for (int k = 0; k <= doneDelay; k++) begin
                    @(negedge CLOCK_50);
                    box_done = 1'b0;
                end
                box_done = 1'b1;
                @(negedge CLOCK_50);
                box_done = 1'b0;
                if (spurMode) begin
                    @(negedge CLOCK_50);
                    box_done = 1'b1;
                    @(negedge CLOCK_50);
                    box_done = 1'b1;
                end
            end
        end
    end

    // Monitor: each box_start consumes one scoreboard entry.
    always @(negedge CLOCK_50) begin
        if (resetn && box_start) begin
            phaseStarts++;
            if (phaseStarts == 1) firstStartCyc = cycleCount;
            lastStartCyc = cycleCount;
            if (phaseStarts == 14) begin
                cell14X = box_x0;
                cell14Y = box_y0;
                cell14Color = box_color;
            end
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_box_start actual=addr %0d expected=no start", cell_rd_addr);
            end else begin
                cell_exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("cell_addr%0d", e.addr),
                            {28'd0, cell_rd_addr, box_x0, box_y0, box_color}, {28'd0, e});
            end
        end
        if (resetn && frame_done) begin
            phaseDone++;
            doneCyc = cycleCount;
        end
    end

    task automatic pushFrame();
        cell_exp_t e;
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 10; c++) begin
                e.addr  = 8'(r * 10 + c);
                e.x0    = 10'(c * 64);
                e.y0    = 9'(r * 24);
                e.color = expPalette[mem[r * 10 + c]];
                expQ.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus();
        @(negedge CLOCK_50);
        frame_req = 1'b1;
        @(negedge CLOCK_50);
        frame_req = 1'b0;
    endtask

    task automatic resetPhase();
        phaseStarts = 0;
        phaseDone = 0;
    endtask

    task automatic waitFrames(input int target, input int budget, input string name);
        int n = 0;
        while (phaseDone < target && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        checkOutput(name, 64'(phaseDone), 64'(target));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_box_start"}, 64'(box_start), 64'd0);
        checkOutput({tag, "_frame_busy"}, 64'(frame_busy), 64'd0);
        checkOutput({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({tag, "_rd_addr"}, 64'(cell_rd_addr), 64'd0);
        checkOutput({tag, "_x0"}, 64'(box_x0), 64'd0);
        checkOutput({tag, "_y0"}, 64'(box_y0), 64'd0);
        checkOutput({tag, "_color"}, 64'(box_color), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 200; i++) mem[i] = 3'((i * 3) % 8);
        mem[13] = 3'd5;

        // Reset and idle-after-reset
        repeat (5) @(negedge CLOCK_50);
        checkResetOutputs("por");
        resetn = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        checkOutput("idle_no_start", 64'(phaseStarts), 64'd0);
        checkOutput("idle_not_busy", 64'(frame_busy), 64'd0);

        // Single frame, drawer done 5 cycles after start
        resetPhase();
        doneDelay = 5;
        pushFrame();
        applyStimulus();
        waitFrames(1, 3000, "frame1_done");
        repeat (10) @(negedge CLOCK_50);
        checkOutput("frame1_starts", 64'(phaseStarts), 64'd200);
        checkOutput("frame1_done_count", 64'(phaseDone), 64'd1);
        checkOutput("frame1_queue_left", 64'(expQ.size()), 64'd0);
        checkOutput("frame1_idle", 64'(frame_busy), 64'd0);
        checkOutput("start14_x0", 64'(cell14X), 64'd192);
        checkOutput("start14_y0", 64'(cell14Y), 64'd24);
        checkOutput("start14_color", 64'(cell14Color), 64'h1C0);

        // Stray done pulses outside WAIT
        resetPhase();
        doneDelay = 2;
        spurMode = 1'b1;
        pushFrame();
        applyStimulus();
        waitFrames(1, 3000, "spur_done");
        repeat (10) @(negedge CLOCK_50);
        spurMode = 1'b0;
        checkOutput("spur_starts", 64'(phaseStarts), 64'd200);
        checkOutput("spur_queue_left", 64'(expQ.size()), 64'd0);

        // Minimum-latency drawer: 5-cycle cell period
        resetPhase();
        doneDelay = 0;
        pushFrame();
        applyStimulus();
        waitFrames(1, 1500, "timing_done");
        checkOutput("timing_start_span", 64'(lastStartCyc - firstStartCyc), 64'd995);
        checkOutput("timing_done_offset", 64'(doneCyc - firstStartCyc), 64'd998);
        repeat (10) @(negedge CLOCK_50);

        // Three mid-frame requests merge into one extra frame
        resetPhase();
        pushFrame();
        pushFrame();
        applyStimulus();
        repeat (100) @(negedge CLOCK_50);
        for (int p = 0; p < 3; p++) begin
            applyStimulus();
            repeat (3) @(negedge CLOCK_50);
        end
        waitFrames(2, 3000, "pending_done");
        repeat (30) @(negedge CLOCK_50);
        checkOutput("pending_done_count", 64'(phaseDone), 64'd2);
        checkOutput("pending_starts", 64'(phaseStarts), 64'd400);
        checkOutput("pending_queue_left", 64'(expQ.size()), 64'd0);
        checkOutput("pending_idle", 64'(frame_busy), 64'd0);

        // Reset during WAIT of cell 57, then restart from address 0
        resetPhase();
        doneDelay = 5;
        pushFrame();
        applyStimulus();
        begin
            int n = 0;
            while (phaseStarts < 58 && n < 1000) begin
                @(negedge CLOCK_50);
                n++;
            end
        end
        checkOutput("midreset_reached", 64'(phaseStarts), 64'd58);
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b0;
        @(posedge CLOCK_50);
        #1;
        checkResetOutputs("midreset");
        expQ.delete();
        repeat (10) @(negedge CLOCK_50);
        resetn = 1'b1;
        resetPhase();
        repeat (20) @(negedge CLOCK_50);
        checkOutput("midreset_no_restart", 64'(phaseStarts), 64'd0);
        pushFrame();
        applyStimulus();
        waitFrames(1, 3000, "restart_done");
        repeat (10) @(negedge CLOCK_50);
        checkOutput("restart_starts", 64'(phaseStarts), 64'd200);
        checkOutput("restart_queue_left", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_render_seq.md
BOARD_RENDER_SEQ -- requirements
Module: board_render_seq

Interface
REQ-001 SHALL have parameter COLS, default 10, board width in cells.
REQ-002 SHALL have parameter ROWS, default 20, board height in cells.
REQ-003 SHALL have parameter CELL_W, default 64, cell width in pixels.
REQ-004 SHALL have parameter CELL_H, default 24, cell height in pixels.
REQ-005 SHALL have port CLOCK_50  in  1  system clock; all state on its rising edge.
REQ-006 SHALL have port resetn  in  1  reset: asynchronous, active-low.
REQ-007 SHALL have port frame_req  in  1  request a full-board redraw; level or pulse, sampled each cycle.
REQ-008 SHALL have port cell_rd_addr  out  8  board RAM address = row*COLS+col, range 0..199.
REQ-009 SHALL have port cell_rd_data  in  3  cell code from board RAM, valid exactly 1 cycle after address.
REQ-010 SHALL have port box_start  out  1  one-cycle start strobe to the box drawer.
REQ-011 SHALL have port box_x0  out  10  cell top-left X in pixels.
REQ-012 SHALL have port box_y0  out  9  cell top-left Y in pixels.
REQ-013 SHALL have port box_color  out  9  RRR_GGG_BBB colour of the current cell.
REQ-014 SHALL have port box_done  in  1  one-cycle completion pulse from the box drawer.
REQ-015 SHALL have port frame_busy  out  1  high from frame accept until frame_done.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse after the last cell completes.

Function
REQ-017 SHALL implement states IDLE, READ, LATCH, ISSUE, WAIT, ADV, FDONE.
REQ-018 IDLE: on frame_req or pending=1 -> READ; clear col, row, addr, x0, y0 to 0; clear pending.
REQ-019 READ: drive cell_rd_addr = addr, one cycle -> LATCH.
REQ-020 LATCH: register box_color = palette(cell_rd_data) -> ISSUE.
REQ-021 ISSUE: box_start=1 for exactly one cycle -> WAIT.
REQ-022 WAIT: hold box_x0/box_y0/box_color stable; on box_done -> ADV; no timeout.
REQ-023 ADV: if col<COLS-1: col+1, addr+1, x0+CELL_W -> READ; else if row<ROWS-1: col=0, x0=0, row+1, addr+1, y0+CELL_H -> READ; else -> FDONE.
REQ-024 FDONE: frame_done=1 one cycle -> IDLE.
REQ-025 Coordinates SHALL be generated by accumulators (add CELL_W / CELL_H), no multipliers; addr by increment.
REQ-026 Palette: 0=9'h000, 1=9'h03F(cyan), 2=9'h1F8(yellow), 3=9'h1C7(magenta), 4=9'h038(green), 5=9'h1C0(red), 6=9'h007(blue), 7=9'h1E0(orange).
REQ-027 frame_req while frame_busy=1 SHALL set a one-deep pending flag; further requests while pending=1 are merged.
REQ-028 box_done outside WAIT SHALL be ignored; box_done in the same cycle as box_start SHALL NOT advance state.
REQ-029 frame_busy SHALL be 1 in READ..ADV and FDONE, 0 in IDLE.
REQ-030 Per-cell overhead SHALL be exactly 4 cycles (READ, LATCH, ISSUE, ADV) plus WAIT duration.
REQ-031 Last cell SHALL be addr 199, x0=576, y0=456 with defaults.

Reset
REQ-032 resetn=0 SHALL force IDLE and clear pending, col, row, addr, x0, y0 immediately, including mid-frame.
REQ-033 Reset values: box_start=0, frame_busy=0, frame_done=0, cell_rd_addr=0, box_x0=0, box_y0=0, box_color=0.
REQ-034 After reset release, no frame SHALL start until frame_req is seen.

Structure
REQ-035 Shared package SHALL hold COLS, ROWS, CELL_W, CELL_H, the 3-bit cell code constants and the 8-entry palette.
REQ-036 Palette lookup SHALL be one combinational sub-module cell_palette (3-bit code in, 9-bit colour out).
REQ-037 The box drawer SHALL NOT be instantiated inside this block; the top connects the two.

Verification
REQ-038 Reset, single frame_req, drawer model with done 5 cycles after start -> 200 box_start pulses, addresses 0..199 in order, one frame_done.
REQ-039 RAM cell 13 = code 5 -> at start #14: box_x0=192, box_y0=24, box_color=9'h1C0.
REQ-040 frame_req pulsed 3 times mid-frame -> exactly one extra frame follows, then IDLE.
REQ-041 Spurious box_done in READ/LATCH/ISSUE -> no skipped cells, order unchanged.
REQ-042 resetn low during cell 57 WAIT -> all outputs to reset values next edge; new frame_req restarts at addr 0.
REQ-043 Drawer done delay 0 after start (done in cycle after ISSUE) -> cell period exactly 5 cycles, 1000 cycles + FDONE per frame.
